// File: rtl/mips_pkg.sv
// Shared types and defaults for the fetch / next-PC slice.
package mips_pkg;

    localparam int unsigned        DEFAULT_ADDRESS_WIDTH = 32;
    localparam logic [31:0]        DEFAULT_RESET_VECTOR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_PLUS4,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control inputs and PC/status outputs of the fetch PC unit.
interface fetch_pc_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH   = 32
);
    logic                     Stall;
    logic                     Branch;
    logic                     Jump;
    logic                     JumpReg;
    logic [ADDRESS_WIDTH-1:0] BranchImm;
    logic [25:0]              JumpIndex;
    logic [ADDRESS_WIDTH-1:0] RegTarget;

    logic [ADDRESS_WIDTH-1:0] PC;
    logic [ADDRESS_WIDTH-1:0] PCPlus4;
    logic                     Halted;
    logic                     AddrFault;
    logic [COUNT_WIDTH-1:0]   InstrCount;
    logic [COUNT_WIDTH-1:0]   RedirectCount;

    modport master (
        output Stall, Branch, Jump, JumpReg, BranchImm, JumpIndex, RegTarget,
        input  PC, PCPlus4, Halted, AddrFault, InstrCount, RedirectCount
    );

    modport slave (
        input  Stall, Branch, Jump, JumpReg, BranchImm, JumpIndex, RegTarget,
        output PC, PCPlus4, Halted, AddrFault, InstrCount, RedirectCount
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC target computation, priority select and fetch-range legality check.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned MEM_DEPTH     = 100
) (
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic                     branch,
    input  logic                     jump,
    input  logic                     jump_reg,
    input  logic [ADDRESS_WIDTH-1:0] branch_imm,
    input  logic [25:0]              jump_index,
    input  logic [ADDRESS_WIDTH-1:0] reg_target,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic [ADDRESS_WIDTH-1:0] next_pc,
    output pc_sel_e                  sel,
    output logic                     illegal
);

    // Compared in 64 bits so a depth near 2^ADDRESS_WIDTH cannot truncate the limit.
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'd4;

    logic [ADDRESS_WIDTH-1:0] branch_target;
    logic [ADDRESS_WIDTH-1:0] jump_target;

    assign pc_plus4      = pc + ADDRESS_WIDTH'(4);
    assign branch_target = pc_plus4 + (branch_imm << 2);
    assign jump_target   = {pc_plus4[ADDRESS_WIDTH-1:28], jump_index, 2'b00};

    always_comb begin
        sel     = SEL_PLUS4;
        next_pc = pc_plus4;
        if (jump_reg) begin
            sel     = SEL_JR;
            next_pc = reg_target;
        end else if (jump) begin
            sel     = SEL_JUMP;
            next_pc = jump_target;
        end else if (branch) begin
            sel     = SEL_BRANCH;
            next_pc = branch_target;
        end
    end

    assign illegal = (next_pc[1:0] != 2'b00) || (64'(next_pc) >= MEM_BYTES);

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural PC register, boot/run/halt FSM and fetch counters.
// Define FETCH_PERF_CNT_EN to build the InstrCount/RedirectCount counters.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned              MEM_DEPTH     = 100,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned              COUNT_WIDTH   = 32
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_unit_if.slave bus
);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] next_pc;
    pc_sel_e                  sel;
    logic                     illegal;
    fetch_state_e             state_q;
    logic                     halted_q;
    logic                     fault_q;
    logic                     update;

    pc_next_mux #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .MEM_DEPTH     (MEM_DEPTH)
    ) u_pc_next_mux (
        .pc         (pc_q),
        .branch     (bus.Branch),
        .jump       (bus.Jump),
        .jump_reg   (bus.JumpReg),
        .branch_imm (bus.BranchImm),
        .jump_index (bus.JumpIndex),
        .reg_target (bus.RegTarget),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .sel        (sel),
        .illegal    (illegal)
    );

    assign update = (state_q == RUN) && !bus.Stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_VECTOR;
            state_q  <= BOOT;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (!bus.Stall) begin
                        if (illegal) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            pc_q <= next_pc;
                            // Jump-to-self idiom: the program has parked itself.
                            if (next_pc == pc_q) begin
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end
                        end
                    end
                end
                HALT: ;
                default: begin
                    halted_q <= 1'b1;
                    state_q  <= HALT;
                end
            endcase
        end
    end

    assign bus.PC        = pc_q;
    assign bus.PCPlus4   = pc_plus4;
    assign bus.Halted    = halted_q;
    assign bus.AddrFault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [COUNT_WIDTH-1:0] instr_cnt_q;
    logic [COUNT_WIDTH-1:0] redirect_cnt_q;
    logic                   retire;
    logic                   redirect;

    assign retire   = update && !illegal;
    assign redirect = retire && (sel != SEL_PLUS4);

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (retire && (instr_cnt_q != '1)) begin
                instr_cnt_q <= instr_cnt_q + COUNT_WIDTH'(1);
            end
            if (redirect && (redirect_cnt_q != '1)) begin
                redirect_cnt_q <= redirect_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.InstrCount    = instr_cnt_q;
    assign bus.RedirectCount = redirect_cnt_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs  = update ^ (^sel);
    assign bus.InstrCount     = '0;
    assign bus.RedirectCount  = '0;
`endif

endmodule
